// File: rtl/counter_seq_pkg.sv
// ============================================================================
// Module   : counter_seq_pkg
// Purpose  : Shared types and constants for the counter run-control sequencer.
//            Holds the sequencer state encoding and the run-mode constants.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/counter_sequencer_count_reg.sv
// ============================================================================
// Module   : count_reg
// Purpose  : WIDTH-bit up-counter register with clear / increment / hold.
//            Clear has priority over increment; with neither asserted the
//            value holds.
// Ports    : clk    - system clock
//            reset  - asynchronous active-low reset (q -> 0)
//            clr    - synchronous clear to 0
//            inc    - synchronous increment by one
//            q      - current count
//            qbar   - bitwise inverse of q
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module count_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q + 1'b1;
    end
  end

  assign qbar = ~q;

endmodule

`default_nettype wire

// File: rtl/counter_sequencer.sv
// ============================================================================
// Module   : counter_sequencer
// Purpose  : Run-control sequencer for a WIDTH-bit up-counter. Accepts
//            start/stop/pause commands with a programmable terminal value and
//            runs the counter one-shot or auto-reload, reporting terminal
//            count, completion, rejected launches and reload wraps.
// Ports    : clk    - system clock
//            reset  - asynchronous active-low reset
//            start  - launch request (honoured in IDLE and DONE only)
//            stop   - abort to IDLE, highest priority
//            pause  - level, freezes counting in RUN/HOLD
//            mode   - 0 one-shot, 1 auto-reload (latched at launch)
//            limit  - terminal count (latched at launch, 0 is rejected)
//            q/qbar - count and its inverse
//            busy   - RUN or HOLD
//            done   - DONE state
//            tc     - terminal-count strobe (combinational)
//            err    - one-cycle pulse after a rejected launch
//            wraps  - saturating reload-wrap count since last launch
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             busy,
  output logic             done,
  output logic             tc,
  output logic             err,
  output logic [WRAPW-1:0] wraps
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] limit_r;
  logic             mode_r;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             launch;
  logic             wrap_inc;
  logic             err_nxt;
  logic             at_limit;

  count_reg #(
    .WIDTH (WIDTH)
  ) u_count_reg (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .q     (q),
    .qbar  (qbar)
  );

  assign at_limit = (q == limit_r);

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    launch    = 1'b0;
    wrap_inc  = 1'b0;
    err_nxt   = 1'b0;
    tc        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!stop && start) begin
          if (limit != '0) begin
            launch    = 1'b1;
            state_nxt = ST_RUN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          cnt_clr   = 1'b1;
        end else if (pause) begin
          state_nxt = ST_HOLD;
        end else if (at_limit) begin
          tc = 1'b1;
          if (mode_r == MODE_RELOAD) begin
            cnt_clr  = 1'b1;
            wrap_inc = 1'b1;
          end else begin
            // q is already at limit_r, so DONE holds it by not touching q
            state_nxt = ST_DONE;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_HOLD: begin
        // Returning to RUN only re-enables counting; the terminal check
        // happens in RUN so a release at the limit still yields one tc.
        if (stop) begin
          state_nxt = ST_IDLE;
          cnt_clr   = 1'b1;
        end else if (!pause) begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          cnt_clr   = 1'b1;
        end else if (start) begin
          if (limit != '0) begin
            launch    = 1'b1;
            state_nxt = ST_RUN;
            cnt_clr   = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      limit_r <= '0;
      mode_r  <= MODE_ONESHOT;
      wraps   <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      err   <= err_nxt;
      if (launch) begin
        limit_r <= limit;
        mode_r  <= mode;
        wraps   <= '0;
      end else if (wrap_inc && (wraps != {WRAPW{1'b1}})) begin
        wraps <= wraps + 1'b1;
      end
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_HOLD);
  assign done = (state == ST_DONE);

endmodule

`default_nettype wire

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Run-control sequencer for a WIDTH-bit up-counter, the count datapath used by the basics counters (q/qbar outputs).
- Accepts start/stop/pause commands and a programmable terminal value, then steps the counter.
- Reports terminal count, completion and reload wraps, so one counter can be run one-shot or periodically under FSM control.
- Instantiated between a command source (testbench or top-level control logic) and whatever consumes q.

Parameters:
- WIDTH, 4: counter and limit width in bits.
- WRAPW, 8: width of the reload-wrap counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  launch request; sampled in IDLE and DONE only.
- stop  input  1  abort to IDLE; highest priority.
- pause  input  1  level; freezes counting while high in RUN/HOLD.
- mode  input  1  0 = one-shot, 1 = auto-reload; latched at launch.
- limit  input  WIDTH  terminal count value; latched at launch.
- q  output  WIDTH  current count.
- qbar  output  WIDTH  bitwise inverse of q, always equal to ~q.
- busy  output  1  high in RUN or HOLD.
- done  output  1  level, high in DONE.
- tc  output  1  terminal-count strobe (Mealy).
- err  output  1  one-cycle pulse on a rejected launch.
- wraps  output  WRAPW  number of auto-reload wraps since the last launch; saturates at all-ones.

Behaviour:
- States: IDLE, RUN, HOLD, DONE. Encoding lives in the package.
- Reset (reset=0, asynchronous) forces: state IDLE; q=0; qbar all-ones; limit_r=0; mode_r=0; wraps=0; err=0. Outputs busy, done and tc are therefore 0.
- Command priority in every state: stop > start/pause > count.
- IDLE:
  - q held at 0.
  - start=1 with limit!=0 and stop=0: latch limit_r/mode_r, clear wraps, go to RUN. q is still 0 in the first RUN cycle.
  - start=1 with limit==0: stay in IDLE, err=1 for the next cycle only.
- RUN:
  - If stop: go to IDLE, q=0.
  - Else if pause: go to HOLD, q unchanged.
  - Else if q==limit_r: assert tc this cycle.
    - mode_r=0: go to DONE, q holds limit_r.
    - mode_r=1: q=0, wraps+1 (saturating), stay in RUN.
  - Else: q=q+1.
  - Latency: one-shot done rises limit_r+1 cycles after the start edge.
- HOLD:
  - q frozen; tc=0.
  - If stop: go to IDLE.
  - Else if pause=0: go to RUN; counting resumes on the next edge.
- DONE:
  - q holds limit_r; done=1.
  - If stop: go to IDLE, q=0.
  - Else if start: relaunch as from IDLE, including the limit==0 rejection.
- tc = (state==RUN) && (q==limit_r) && !pause && !stop. Exactly one tc pulse per terminal event, including when pause releases at the terminal value.
- start while busy is ignored, with no err.
- start and stop together: stop wins, no err.
- q wraps only via reload; with limit_r <= 2^WIDTH-1 there is no arithmetic overflow.
- Reset asserted mid-RUN or mid-HOLD: immediate return to reset values; no tc or done is generated.

Decomposition:
- Package counter_seq_pkg: state enum (IDLE=2'b00, RUN=2'b01, HOLD=2'b10, DONE=2'b11) and the MODE_ONESHOT/MODE_RELOAD constants.
- Sub-module count_reg: WIDTH-bit register with clear/increment/hold controls, async active-low reset, and q/qbar outputs. The FSM in counter_sequencer drives its controls.

Test Plan:
1. Reset low for 3 cycles mid-RUN, then release -> q=0, qbar=4'hF, busy=0, done=0, wraps=0 immediately on assertion.
2. limit=5, mode=0, start pulse -> q sequence 0,1,2,3,4,5; tc high 1 cycle at q=5; done=1 next cycle with q=5; busy low.
3. limit=3, mode=1, run 12 cycles -> q cycles 0..3 repeatedly; tc every 4th cycle; wraps=3 after 3 terminal events. Force 300 wraps with WRAPW=8 -> wraps saturates at 8'hFF.
4. limit=6, pause high at q=2 for 4 cycles, then low -> q stays 2, tc=0; counting resumes 3,4,5,6; single tc at q=6.
5. limit=0 with start -> err pulses 1 cycle, state stays IDLE. start=1 and stop=1 together with limit=4 -> stays IDLE, no err.
6. In DONE (limit=2), start with limit=9 -> relaunch, q counts to 9, done again. stop during RUN at q=5 -> q=0, state IDLE next cycle, no tc.
